// File: rtl/hsid_pkg.sv
// ============================================================================
// Module  : hsid_pkg
// Brief   : Shared widths, constants and main-controller state encoding for
//           the hyperspectral pixel identification datapath.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package hsid_pkg;

    localparam int HSID_WORD_WIDTH        = 32;
    localparam int HSID_HSP_BANDS_WIDTH   = 8;
    localparam int HSID_HSP_LIBRARY_WIDTH = 11;
    localparam int HSID_BANDS_PER_WORD    = 2;

    typedef enum logic [2:0] {
        HSID_IDLE         = 3'd0,
        HSID_READ_MEASURE = 3'd1,
        HSID_COMPUTE_MSE  = 3'd2,
        HSID_WAIT_MSE     = 3'd3,
        HSID_COMPARE_MSE  = 3'd4,
        HSID_DONE         = 3'd5
    } hsid_main_state_t;

endpackage

`default_nettype wire

// File: rtl/hsid_main_ctrl_min_tracker.sv
// ============================================================================
// Module  : hsid_main_ctrl_min_tracker
// Brief   : Running-minimum register with the library index it came from.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module hsid_main_ctrl_min_tracker
    import hsid_pkg::*;
#(
    parameter int WORD_WIDTH    = HSID_WORD_WIDTH,
    parameter int LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     init_i,
    input  logic                     cmp_en_i,
    input  logic [WORD_WIDTH-1:0]    value_i,
    input  logic [LIBRARY_WIDTH-1:0] index_i,
    output logic [WORD_WIDTH-1:0]    min_value_o,
    output logic [LIBRARY_WIDTH-1:0] min_index_o
);

    logic [WORD_WIDTH-1:0]    min_d, min_q;
    logic [LIBRARY_WIDTH-1:0] idx_d, idx_q;

    // Strict less-than: on a tie the earlier library index is kept.
    always_comb begin
        min_d = min_q;
        idx_d = idx_q;
        if (init_i) begin
            min_d = '1;
            idx_d = '0;
        end else if (cmp_en_i && (value_i < min_q)) begin
            min_d = value_i;
            idx_d = index_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_q <= '1;
            idx_q <= '0;
        end else begin
            min_q <= min_d;
            idx_q <= idx_d;
        end
    end

    assign min_value_o = min_q;
    assign min_index_o = idx_q;

endmodule

`default_nettype wire

// File: rtl/hsid_main_ctrl.sv
// ============================================================================
// Module  : hsid_main_ctrl
// Brief   : Top-level sequencer: loads the measured pixel, streams library
//           band packs to the MSE unit and keeps the best-matching index.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module hsid_main_ctrl
    import hsid_pkg::*;
#(
    parameter int WORD_WIDTH    = HSID_WORD_WIDTH,
    parameter int BANDS_WIDTH   = HSID_HSP_BANDS_WIDTH,
    parameter int LIBRARY_WIDTH = HSID_HSP_LIBRARY_WIDTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     clear_i,
    input  logic [LIBRARY_WIDTH-1:0] library_size_i,
    input  logic [BANDS_WIDTH-1:0]   hsp_bands_i,
    output logic                     measure_req_o,
    input  logic                     measure_done_i,
    input  logic                     lib_valid_i,
    output logic                     lib_ready_o,
    output logic                     mse_in_valid_o,
    output logic                     mse_in_last_o,
    input  logic                     mse_valid_i,
    input  logic [WORD_WIDTH-1:0]    mse_value_i,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [2:0]               state_o,
    output logic [WORD_WIDTH-1:0]    min_mse_o,
    output logic [LIBRARY_WIDTH-1:0] min_index_o
);

    hsid_main_state_t         state_d, state_q;
    logic [LIBRARY_WIDTH-1:0] lib_size_d, lib_size_q;
    logic [BANDS_WIDTH-1:0]   hsp_bands_d, hsp_bands_q;
    logic [LIBRARY_WIDTH-1:0] lib_idx_d, lib_idx_q;
    logic [BANDS_WIDTH-1:0]   pack_cnt_d, pack_cnt_q;
    logic [WORD_WIDTH-1:0]    mse_value_d, mse_value_q;

    logic busy_q, done_q, measure_req_q, lib_ready_q;
    logic trk_init, trk_cmp;

    // Two bands share a word; an odd count rounds up, the datapath masks the pad.
    logic [BANDS_WIDTH:0]   packs_sum;
    logic [BANDS_WIDTH-1:0] packs;
    logic [BANDS_WIDTH-1:0] last_pack;
    logic                   is_last_pack;
    logic                   is_last_pixel;

    assign packs_sum     = {1'b0, hsp_bands_q} + (BANDS_WIDTH + 1)'(HSID_BANDS_PER_WORD - 1);
    assign packs         = packs_sum[BANDS_WIDTH:1];
    assign last_pack     = packs - BANDS_WIDTH'(1);
    assign is_last_pack  = (pack_cnt_q == last_pack);
    assign is_last_pixel = (lib_idx_q == (lib_size_q - LIBRARY_WIDTH'(1)));

    always_comb begin
        state_d     = state_q;
        lib_size_d  = lib_size_q;
        hsp_bands_d = hsp_bands_q;
        lib_idx_d   = lib_idx_q;
        pack_cnt_d  = pack_cnt_q;
        mse_value_d = mse_value_q;
        trk_init    = 1'b0;
        trk_cmp     = 1'b0;

        if (clear_i) begin
            state_d    = HSID_IDLE;
            lib_idx_d  = '0;
            pack_cnt_d = '0;
            trk_init   = 1'b1;
        end else begin
            case (state_q)
                HSID_IDLE, HSID_DONE: begin
                    if (start_i) begin
                        lib_size_d  = library_size_i;
                        hsp_bands_d = hsp_bands_i;
                        lib_idx_d   = '0;
                        pack_cnt_d  = '0;
                        trk_init    = 1'b1;
                        state_d     = ((library_size_i == '0) || (hsp_bands_i == '0))
                                      ? HSID_DONE : HSID_READ_MEASURE;
                    end
                end
                HSID_READ_MEASURE: begin
                    if (measure_done_i) state_d = HSID_COMPUTE_MSE;
                end
                HSID_COMPUTE_MSE: begin
                    if (lib_valid_i) begin
                        pack_cnt_d = pack_cnt_q + BANDS_WIDTH'(1);
                        if (is_last_pack) state_d = HSID_WAIT_MSE;
                    end
                end
                HSID_WAIT_MSE: begin
                    if (mse_valid_i) begin
                        mse_value_d = mse_value_i;
                        state_d     = HSID_COMPARE_MSE;
                    end
                end
                HSID_COMPARE_MSE: begin
                    trk_cmp = 1'b1;
                    if (is_last_pixel) begin
                        state_d = HSID_DONE;
                    end else begin
                        lib_idx_d  = lib_idx_q + LIBRARY_WIDTH'(1);
                        pack_cnt_d = '0;
                        state_d    = HSID_COMPUTE_MSE;
                    end
                end
                default: state_d = HSID_IDLE;
            endcase
        end
    end

    // Status/handshake outputs are registered off the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= HSID_IDLE;
            lib_size_q    <= '0;
            hsp_bands_q   <= '0;
            lib_idx_q     <= '0;
            pack_cnt_q    <= '0;
            mse_value_q   <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            measure_req_q <= 1'b0;
            lib_ready_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            lib_size_q    <= lib_size_d;
            hsp_bands_q   <= hsp_bands_d;
            lib_idx_q     <= lib_idx_d;
            pack_cnt_q    <= pack_cnt_d;
            mse_value_q   <= mse_value_d;
            busy_q        <= (state_d != HSID_IDLE) && (state_d != HSID_DONE);
            done_q        <= (state_d == HSID_DONE);
            measure_req_q <= (state_d == HSID_READ_MEASURE);
            lib_ready_q   <= (state_d == HSID_COMPUTE_MSE);
        end
    end

    hsid_main_ctrl_min_tracker #(
        .WORD_WIDTH    (WORD_WIDTH),
        .LIBRARY_WIDTH (LIBRARY_WIDTH)
    ) u_min_tracker (
        .clk         (clk),
        .rst         (rst),
        .init_i      (trk_init),
        .cmp_en_i    (trk_cmp),
        .value_i     (mse_value_q),
        .index_i     (lib_idx_q),
        .min_value_o (min_mse_o),
        .min_index_o (min_index_o)
    );

    assign measure_req_o  = measure_req_q;
    assign lib_ready_o    = lib_ready_q;
    assign mse_in_valid_o = lib_valid_i && lib_ready_q;
    assign mse_in_last_o  = mse_in_valid_o && is_last_pack;
    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign state_o        = state_q;

endmodule

`default_nettype wire

// File: tb/tb_hsid_main_ctrl.sv
// ============================================================================
// Module  : tb_hsid_main_ctrl
// Brief   : Scoreboard bench for hsid_main_ctrl with a pixel-level reference.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hsid_main_ctrl;
    import hsid_pkg::*;

    localparam int W  = 32;
    localparam int BW = 8;
    localparam int LW = 11;

    logic          clk, rst, start_i, clear_i;
    logic [LW-1:0] library_size_i;
    logic [BW-1:0] hsp_bands_i;
    logic          measure_req_o, measure_done_i, lib_valid_i, lib_ready_o;
    logic          mse_in_valid_o, mse_in_last_o, mse_valid_i;
    logic [W-1:0]  mse_value_i;
    logic          busy_o, done_o;
    logic [2:0]    state_o;
    logic [W-1:0]  min_mse_o;
    logic [LW-1:0] min_index_o;

    hsid_main_ctrl dut (
        .clk(clk), .rst(rst), .start_i(start_i), .clear_i(clear_i),
        .library_size_i(library_size_i), .hsp_bands_i(hsp_bands_i),
        .measure_req_o(measure_req_o), .measure_done_i(measure_done_i),
        .lib_valid_i(lib_valid_i), .lib_ready_o(lib_ready_o),
        .mse_in_valid_o(mse_in_valid_o), .mse_in_last_o(mse_in_last_o),
        .mse_valid_i(mse_valid_i), .mse_value_i(mse_value_i),
        .busy_o(busy_o), .done_o(done_o), .state_o(state_o),
        .min_mse_o(min_mse_o), .min_index_o(min_index_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  min;
        logic [LW-1:0] idx;
        bit            req;
        int            xfers;
    } exp_res_t;

    int           vectors = 0;
    int           miscompares = 0;
    exp_res_t     q_res[$];
    bit           q_last[$];
    bit           ignore_xfer = 1'b0;
    logic [W-1:0] case_vals[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pixel-level reference: packs per pixel and running strict minimum.
    function automatic exp_res_t model(input int lib, input int bands);
        exp_res_t e;
        int packs;
        packs   = (bands + 1) / 2;
        e.min   = '1;
        e.idx   = '0;
        e.req   = (lib != 0) && (bands != 0);
        e.xfers = e.req ? lib * packs : 0;
        if (e.req)
            for (int i = 0; i < lib; i++)
                if (case_vals[i] < e.min) begin
                    e.min = case_vals[i];
                    e.idx = LW'(i);
                end
        return e;
    endfunction

    // Monitor: pops expected last flags per transfer and expected results at DONE.
    int xfer_cnt = 0;
    bit req_seen = 1'b0;
    bit prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_done = 1'b0;
        end else begin
            if (start_i && (state_o == 3'd0 || state_o == 3'd5)) begin
                xfer_cnt = 0;
                req_seen = 1'b0;
            end
            if (measure_req_o) req_seen = 1'b1;
            if (mse_in_valid_o && !ignore_xfer) begin
                xfer_cnt++;
                if (q_last.size() == 0) check("unexpected_xfer", 64'd1, 64'd0);
                else check("mse_in_last", 64'(mse_in_last_o), 64'(q_last.pop_front()));
            end
            if (done_o && !prev_done && !ignore_xfer) begin
                if (q_res.size() == 0) begin
                    check("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_res_t e;
                    e = q_res.pop_front();
                    check("min_mse", 64'(min_mse_o), 64'(e.min));
                    check("min_index", 64'(min_index_o), 64'(e.idx));
                    check("measure_req_seen", 64'(req_seen), 64'(e.req));
                    check("xfer_count", 64'(xfer_cnt), 64'(e.xfers));
                    check("done_busy", 64'(busy_o), 64'd0);
                    check("done_state", 64'(state_o), 64'd5);
                end
            end
            prev_done = done_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int c = 0;
        while (!measure_req_o && c < 50) begin tick(); c++; end
        if (c >= 50) check("measure_req_timeout", 64'd0, 64'd1);
    endtask

    task automatic wait_done();
        int c = 0;
        while (!done_o && c < 200) begin tick(); c++; end
        if (c >= 200) check("done_timeout", 64'd0, 64'd1);
    endtask

    task automatic pulse_clear();
        clear_i = 1'b1;
        tick();
        clear_i = 1'b0;
        tick();
    endtask

    // Runs one full identification; pixel values come from case_vals.
    task automatic run_case(input int lib, input int bands, input bit noisy);
        exp_res_t e;
        int packs;
        e     = model(lib, bands);
        packs = (bands + 1) / 2;
        q_res.push_back(e);
        if (e.req)
            for (int p = 0; p < lib; p++)
                for (int k = 0; k < packs; k++) q_last.push_back(k == packs - 1);
        start_i        = 1'b1;
        library_size_i = LW'(lib);
        hsp_bands_i    = BW'(bands);
        tick();
        start_i        = 1'b0;
        library_size_i = LW'($urandom);
        hsp_bands_i    = BW'($urandom);
        if (e.req) begin
            wait_req();
            repeat ($urandom_range(0, 3)) tick();
            measure_done_i = 1'b1;
            tick();
            measure_done_i = 1'b0;
            for (int p = 0; p < lib; p++) begin
                int  sent = 0;
                int  c    = 0;
                bit  xf;
                while (sent < packs && c < 2000) begin
                    lib_valid_i = noisy ? ($urandom_range(0, 3) != 0) : 1'b1;
                    mse_valid_i = noisy && lib_ready_o && ($urandom_range(0, 7) == 0);
                    mse_value_i = '0;
                    start_i     = noisy && ($urandom_range(0, 15) == 0);
                    @(negedge clk);
                    xf = lib_valid_i && lib_ready_o;
                    tick();
                    if (xf) sent++;
                    c++;
                end
                if (c >= 2000) check("pack_timeout", 64'd0, 64'd1);
                lib_valid_i = 1'b0;
                mse_valid_i = 1'b0;
                start_i     = 1'b0;
                if (noisy) repeat ($urandom_range(0, 3)) tick();
                mse_valid_i = 1'b1;
                mse_value_i = case_vals[p];
                tick();
                mse_valid_i = 1'b0;
                mse_value_i = W'($urandom);
            end
        end
        wait_done();
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        rst = 1'b1; start_i = 1'b0; clear_i = 1'b0;
        library_size_i = '0; hsp_bands_i = '0;
        measure_done_i = 1'b0; lib_valid_i = 1'b0;
        mse_valid_i = 1'b0; mse_value_i = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Asynchronous reset while streaming packs.
        ignore_xfer    = 1'b1;
        start_i        = 1'b1;
        library_size_i = LW'(3);
        hsp_bands_i    = BW'(16);
        tick();
        start_i = 1'b0;
        wait_req();
        measure_done_i = 1'b1;
        tick();
        measure_done_i = 1'b0;
        lib_valid_i    = 1'b1;
        repeat (3) tick();
        check("mid_compute_state", 64'(state_o), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        check("rst_state", 64'(state_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_done", 64'(done_o), 64'd0);
        check("rst_measure_req", 64'(measure_req_o), 64'd0);
        check("rst_lib_ready", 64'(lib_ready_o), 64'd0);
        check("rst_mse_in_valid", 64'(mse_in_valid_o), 64'd0);
        check("rst_mse_in_last", 64'(mse_in_last_o), 64'd0);
        check("rst_min_mse", 64'(min_mse_o), 64'hFFFF_FFFF);
        check("rst_min_index", 64'(min_index_o), 64'd0);
        lib_valid_i = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        ignore_xfer = 1'b0;

        // Three pixels, 8 packs each, tie keeps the earlier index.
        case_vals = {32'd500, 32'd120, 32'd120};
        run_case(3, 16, 1'b0);

        // Odd band count rounds up to 3 packs.
        case_vals = {32'd77};
        run_case(1, 5, 1'b0);

        // Clear together with a result in WAIT_MSE.
        ignore_xfer    = 1'b1;
        start_i        = 1'b1;
        library_size_i = LW'(2);
        hsp_bands_i    = BW'(2);
        tick();
        start_i = 1'b0;
        wait_req();
        measure_done_i = 1'b1;
        tick();
        measure_done_i = 1'b0;
        lib_valid_i    = 1'b1;
        begin
            int c = 0;
            while (state_o != 3'd3 && c < 50) begin tick(); c++; end
            if (c >= 50) check("wait_mse_timeout", 64'd0, 64'd1);
        end
        lib_valid_i = 1'b0;
        mse_valid_i = 1'b1;
        mse_value_i = 32'd5;
        clear_i     = 1'b1;
        tick();
        mse_valid_i = 1'b0;
        clear_i     = 1'b0;
        check("clear_state", 64'(state_o), 64'd0);
        check("clear_min_mse", 64'(min_mse_o), 64'hFFFF_FFFF);
        check("clear_min_index", 64'(min_index_o), 64'd0);
        check("clear_busy", 64'(busy_o), 64'd0);
        tick();
        check("clear_stays_idle", 64'(state_o), 64'd0);
        check("clear_not_captured", 64'(min_mse_o), 64'hFFFF_FFFF);
        ignore_xfer = 1'b0;

        case_vals = {32'd300, 32'd7};
        run_case(2, 4, 1'b0);

        // Degenerate configurations go straight to DONE.
        pulse_clear();
        case_vals.delete();
        run_case(0, 8, 1'b0);
        pulse_clear();
        run_case(4, 0, 1'b0);
        pulse_clear();

        // Randomized runs with bubbles, stray results and stray starts.
        for (int t = 0; t < 8; t++) begin
            int lib;
            int bands;
            lib   = $urandom_range(1, 5);
            bands = $urandom_range(1, 20);
            case_vals.delete();
            for (int i = 0; i < lib; i++) case_vals.push_back(W'($urandom_range(1, 40)));
            run_case(lib, bands, 1'b1);
        end

        repeat (3) tick();
        check("leftover_results", 64'(q_res.size()), 64'd0);
        check("leftover_packs", 64'(q_last.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
